// File: rtl/fix_pkg.sv
// Shared types and constants for the FIX session byte-stream front end.
package fix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READY  = 2'd1,
        ST_ACTIVE = 2'd2
    } fix_state_e;

    localparam logic [1:0] CONN_INITIATOR = 2'b01;
    localparam logic [1:0] CONN_ACCEPTOR  = 2'b10;
    localparam logic [7:0] FIX_MSG_END    = 8'h3B;

    typedef struct packed {
        logic [1:0]   conn_type;
        logic [7:0]   reconnect_int;
        logic [15:0]  start_time;
        logic [15:0]  end_time;
        logic [5:0]   begin_string;
        logic [5:0]   default_appl_ver_id;
        logic [255:0] sender_comp_id;
        logic [255:0] target_comp_id;
        logic [15:0]  host_addr;
        logic [7:0]   heart_beat_int;
    } fix_cfg_t;

    function automatic logic conn_type_legal(input logic [1:0] ct, input logic acceptor_en);
        return (ct == CONN_INITIATOR) || (acceptor_en && (ct == CONN_ACCEPTOR));
    endfunction

endpackage

// File: rtl/fix_cfg_regs.sv
// Session configuration register bank with legality check.
// FIX_ACCEPTOR_EN additionally admits the acceptor connect type.
module fix_cfg_regs
    import fix_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     load_i,
    input  fix_cfg_t cfg_i,
    output logic     legal_o
);

`ifdef FIX_ACCEPTOR_EN
    localparam logic ACCEPTOR_EN = 1'b1;
`else
    localparam logic ACCEPTOR_EN = 1'b0;
`endif

    fix_cfg_t cfg_q, cfg_d;

    always_comb begin
        cfg_d = cfg_q;
        if (load_i) begin
            cfg_d = cfg_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_q <= '0;
        end else begin
            cfg_q <= cfg_d;
        end
    end

    // Legality is judged on the latched copy, so a start needs a prior configure edge.
    assign legal_o = conn_type_legal(cfg_q.conn_type, ACCEPTOR_EN) && (cfg_q.heart_beat_int != 8'd0);

endmodule

// File: rtl/fix_dut.sv
// FIX initiator byte-stream front end: session FSM, one-stage byte forwarder, message tracking.
// Optional macro FIX_ACCEPTOR_EN (used in fix_cfg_regs) also allows acceptor sessions.
module fix_dut
    import fix_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         start,
    input  logic         configure,
    input  logic [7:0]   din,
    input  logic [1:0]   connectType,
    input  logic [7:0]   reconnectInt,
    input  logic [15:0]  starttime,
    input  logic [15:0]  endtime,
    input  logic [5:0]   beginstring,
    input  logic [5:0]   defaultApplVerId,
    input  logic [255:0] senderCompId,
    input  logic [255:0] targetCompId,
    input  logic [15:0]  hostAddr,
    input  logic [7:0]   heartBeatInt,
    output logic [7:0]   dout,
    output logic         valid
);

    fix_state_e  state_q, state_d;
    fix_cfg_t    cfg_in;
    logic        cfg_legal;
    logic        fwd;
    logic [7:0]  dout_p1_q, dout_p1_d;
    logic        vld_p1_q, vld_p1_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [15:0] msg_cnt_q, msg_cnt_d;

    assign cfg_in = '{
        conn_type:           connectType,
        reconnect_int:       reconnectInt,
        start_time:          starttime,
        end_time:            endtime,
        begin_string:        beginstring,
        default_appl_ver_id: defaultApplVerId,
        sender_comp_id:      senderCompId,
        target_comp_id:      targetCompId,
        host_addr:           hostAddr,
        heart_beat_int:      heartBeatInt
    };

    fix_cfg_regs u_cfg_regs (
        .clk     (clk),
        .reset   (reset),
        .load_i  (configure),
        .cfg_i   (cfg_in),
        .legal_o (cfg_legal)
    );

    // configure dominates start, and also tears down an active session.
    always_comb begin
        state_d = state_q;
        if (configure) begin
            state_d = ST_READY;
        end else if ((state_q == ST_READY) && start && cfg_legal) begin
            state_d = ST_ACTIVE;
        end
    end

    assign fwd = (state_q == ST_ACTIVE) && enable;

    always_comb begin
        dout_p1_d  = dout_p1_q;
        vld_p1_d   = fwd;
        byte_cnt_d = byte_cnt_q;
        msg_cnt_d  = msg_cnt_q;
        if (fwd) begin
            dout_p1_d = din;
            if (din == FIX_MSG_END) begin
                byte_cnt_d = 16'd0;
                msg_cnt_d  = msg_cnt_q + 16'd1;
            end else begin
                byte_cnt_d = byte_cnt_q + 16'd1;
            end
        end
    end

    // Stage p1: registered output byte and strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            dout_p1_q  <= 8'h00;
            vld_p1_q   <= 1'b0;
            byte_cnt_q <= 16'd0;
            msg_cnt_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            dout_p1_q  <= dout_p1_d;
            vld_p1_q   <= vld_p1_d;
            byte_cnt_q <= byte_cnt_d;
            msg_cnt_q  <= msg_cnt_d;
        end
    end

    assign dout  = dout_p1_q;
    assign valid = vld_p1_q;

endmodule

// File: tb/tb_fix_dut.sv
// Self-checking bench for fix_dut: vector table, hand sequences and randomized model comparison.
module tb_fix_dut;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable, start, configure;
    logic [7:0]   din;
    logic [1:0]   connectType;
    logic [7:0]   reconnectInt;
    logic [15:0]  starttime, endtime, hostAddr;
    logic [5:0]   beginstring, defaultApplVerId;
    logic [255:0] senderCompId, targetCompId;
    logic [7:0]   heartBeatInt;
    logic [7:0]   dout;
    logic         valid;

    int total = 0;
    int bad   = 0;

`ifdef FIX_ACCEPTOR_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    // Reference model: session phase 0=idle 1=ready 2=active, stored config, expected outputs.
    int         m_phase;
    logic [1:0] m_ct;
    logic [7:0] m_hb;
    logic [7:0] m_dout;
    logic       m_valid;

    always #5 clk = ~clk;

    fix_dut dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .configure(configure),
        .din(din), .connectType(connectType), .reconnectInt(reconnectInt),
        .starttime(starttime), .endtime(endtime), .beginstring(beginstring),
        .defaultApplVerId(defaultApplVerId), .senderCompId(senderCompId),
        .targetCompId(targetCompId), .hostAddr(hostAddr), .heartBeatInt(heartBeatInt),
        .dout(dout), .valid(valid)
    );

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic bit m_legal();
        return ((m_ct == 2'b01) || (ACC && m_ct == 2'b10)) && (m_hb != 8'd0);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_ct = 2'b00; m_hb = 8'd0; m_dout = 8'h00; m_valid = 1'b0;
    endtask

    // Drive one cycle (called just after a falling edge), advance model, compare after the edge.
    task automatic apply(input bit en, input bit st, input bit cf, input logic [7:0] d,
                         input logic [1:0] ct, input logic [7:0] hb);
        enable = en; start = st; configure = cf; din = d; connectType = ct; heartBeatInt = hb;
        reconnectInt = 8'($urandom); starttime = 16'($urandom); hostAddr = 16'($urandom);
        senderCompId = {8{$urandom}};
        @(posedge clk);
        if (m_phase == 2 && en) begin
            m_dout = d; m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        if (cf) begin
            m_phase = 1; m_ct = ct; m_hb = hb;
        end else if (m_phase == 1 && st && m_legal()) begin
            m_phase = 2;
        end
        #1;
        check("model_valid", {7'd0, valid}, {7'd0, m_valid});
        check("model_dout", dout, m_dout);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_valid_during", {7'd0, valid}, 8'd0);
        check("rst_dout_during", dout, 8'h00);
        @(posedge clk); #1;
        check("rst_valid_after", {7'd0, valid}, 8'd0);
        check("rst_dout_after", dout, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit         en, st, cf;
        logic [7:0] d;
        logic [1:0] ct;
        logic [7:0] hb;
        bit         ev;
        logic [7:0] ed;
    } vec_t;

    vec_t tbl[14];

    initial begin
        reset = 1'b0; enable = 0; start = 0; configure = 0; din = 0;
        connectType = 0; heartBeatInt = 0; reconnectInt = 0; starttime = 0; endtime = 0;
        beginstring = 0; defaultApplVerId = 0; senderCompId = 0; targetCompId = 0; hostAddr = 0;
        model_reset();

        //             en st cf din    ct     hb     ev ed
        tbl[0]  = '{0, 0, 1, 8'h00, 2'b01, 8'h1E, 0, 8'h00};
        tbl[1]  = '{1, 0, 0, 8'h55, 2'b01, 8'h1E, 0, 8'h00};
        tbl[2]  = '{1, 0, 0, 8'h66, 2'b01, 8'h1E, 0, 8'h00};
        tbl[3]  = '{0, 1, 0, 8'h00, 2'b01, 8'h1E, 0, 8'h00};
        tbl[4]  = '{1, 0, 0, 8'h38, 2'b01, 8'h1E, 1, 8'h38};
        tbl[5]  = '{0, 0, 0, 8'hAA, 2'b01, 8'h1E, 0, 8'h38};
        tbl[6]  = '{1, 0, 0, 8'h3D, 2'b01, 8'h1E, 1, 8'h3D};
        tbl[7]  = '{0, 0, 0, 8'hBB, 2'b01, 8'h1E, 0, 8'h3D};
        tbl[8]  = '{1, 0, 0, 8'h46, 2'b01, 8'h1E, 1, 8'h46};
        tbl[9]  = '{0, 0, 0, 8'hCC, 2'b01, 8'h1E, 0, 8'h46};
        tbl[10] = '{1, 0, 0, 8'h3B, 2'b01, 8'h1E, 1, 8'h3B};
        tbl[11] = '{0, 0, 0, 8'hDD, 2'b01, 8'h1E, 0, 8'h3B};
        tbl[12] = '{1, 0, 0, 8'h01, 2'b01, 8'h1E, 1, 8'h01};
        tbl[13] = '{1, 0, 0, 8'h02, 2'b01, 8'h1E, 1, 8'h02};

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 14; i++) begin
            apply(tbl[i].en, tbl[i].st, tbl[i].cf, tbl[i].d, tbl[i].ct, tbl[i].hb);
            check($sformatf("tbl%0d_valid", i), {7'd0, valid}, {7'd0, tbl[i].ev});
            check($sformatf("tbl%0d_dout", i), dout, tbl[i].ed);
        end

        // Acceptor connect type
        do_reset();
        apply(0, 0, 1, 8'h00, 2'b10, 8'h05);
        apply(0, 1, 0, 8'h00, 2'b10, 8'h05);
        apply(1, 0, 0, 8'h41, 2'b10, 8'h05);
        check("acc_valid", {7'd0, valid}, ACC ? 8'd1 : 8'd0);
        check("acc_dout", dout, ACC ? 8'h41 : 8'h00);

        // configure and start together: configure wins, a later start opens the session
        do_reset();
        apply(0, 1, 1, 8'h00, 2'b01, 8'h1E);
        apply(1, 0, 0, 8'h41, 2'b01, 8'h1E);
        check("cfgstart_valid", {7'd0, valid}, 8'd0);
        apply(0, 1, 0, 8'h00, 2'b01, 8'h1E);
        apply(1, 0, 0, 8'h41, 2'b01, 8'h1E);
        check("cfgstart2_valid", {7'd0, valid}, 8'd1);
        check("cfgstart2_dout", dout, 8'h41);

        // zero heartbeat is illegal
        apply(0, 0, 1, 8'h00, 2'b01, 8'h00);
        apply(0, 1, 0, 8'h00, 2'b01, 8'h00);
        apply(1, 0, 0, 8'h77, 2'b01, 8'h00);
        check("hb0_valid", {7'd0, valid}, 8'd0);
        check("hb0_dout", dout, 8'h41);

        // reset between two forwarded bytes
        apply(0, 0, 1, 8'h00, 2'b01, 8'h1E);
        apply(0, 1, 0, 8'h00, 2'b01, 8'h1E);
        apply(1, 0, 0, 8'h11, 2'b01, 8'h1E);
        check("mid_first_dout", dout, 8'h11);
        do_reset();
        apply(1, 0, 0, 8'h22, 2'b01, 8'h1E);
        apply(1, 1, 0, 8'h00, 2'b01, 8'h1E);
        apply(1, 0, 0, 8'h33, 2'b01, 8'h1E);
        check("mid_after_valid", {7'd0, valid}, 8'd0);
        check("mid_after_dout", dout, 8'h00);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                apply($urandom_range(0, 1) == 1,
                      $urandom_range(0, 3) == 0,
                      $urandom_range(0, 15) == 0,
                      ($urandom_range(0, 3) == 0) ? 8'h3B : 8'($urandom),
                      2'($urandom_range(0, 3)),
                      ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
